// File: rtl/data_mem_ctrl.sv
// Byte-addressable data RAM behind a valid/ready request port with a fixed, parametrised access latency.
// Byte/half/word loads and stores; misaligned, illegal-size and out-of-range accesses fault without side effects.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic       DIRECT   = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        err_q, err_d;
  logic        load_q, load_d;
  logic [1:0]  rsz_q, rsz_d;
  logic [1:0]  roff_q, roff_d;
  logic        runs_q, runs_d;

  logic        accept;
  logic        commit;
  logic        c_wen;
  logic [1:0]  c_size;
  logic        c_uns;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_err;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  lane_en;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [ADDR_WIDTH-1:0] idx;

  assign req_ready = ~rst & (state_q != S_BUSY);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = err_q;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_d = DIRECT ? S_RESP : S_BUSY;
          cnt_d   = CNT_INIT;
          wen_d   = req_wen;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero latency the access commits on its own acceptance edge, so it uses the live request.
  always_comb begin
    c_wen   = DIRECT ? req_wen      : wen_q;
    c_size  = DIRECT ? req_size     : size_q;
    c_uns   = DIRECT ? req_unsigned : uns_q;
    c_addr  = DIRECT ? req_addr     : addr_q;
    c_wdata = DIRECT ? req_wdata    : wdata_q;
    commit  = ~rst & (((state_q == S_BUSY) && (cnt_q == 4'd0)) || (DIRECT && accept));
    c_err   = (c_size == 2'b11)
            | ((c_size == 2'b01) & c_addr[0])
            | ((c_size == 2'b10) & (c_addr[1:0] != 2'b00))
            | ((c_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    wr_en   = commit & c_wen & ~c_err;
    rd_en   = commit & ~c_wen & ~c_err;
    idx     = c_addr[ADDR_WIDTH+1:2];
    case (c_size)
      2'b00: begin
        lane_en = 4'b0001 << c_addr[1:0];
        wr_word = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        lane_en = c_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{c_wdata[15:0]}};
      end
      default: begin
        lane_en = 4'b1111;
        wr_word = c_wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte;
      always_ff @(posedge clk) begin
        if (wr_en && lane_en[gi]) mem[idx] <= wr_word[8*gi +: 8];
        if (rd_en) rd_byte <= mem[idx];
      end
      assign rd_word[8*gi +: 8] = rd_byte;
    end
  endgenerate

  // Response descriptor is captured at commit and held, so rsp_rdata stays stable until the next response.
  always_comb begin
    err_d  = err_q;
    load_d = load_q;
    rsz_d  = rsz_q;
    roff_d = roff_q;
    runs_d = runs_q;
    if (commit) begin
      err_d  = c_err;
      load_d = ~c_wen & ~c_err;
      rsz_d  = c_size;
      roff_d = c_addr[1:0];
      runs_d = c_uns;
    end
  end

  always_comb begin
    shifted   = rd_word >> {roff_q, 3'b000};
    rsp_rdata = 32'd0;
    if (load_q) begin
      case (rsz_q)
        2'b00:   rsp_rdata = runs_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
        2'b01:   rsp_rdata = runs_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        default: rsp_rdata = rd_word;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      rsz_q   <= 2'b00;
      roff_q  <= 2'b00;
      runs_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      load_q  <= load_d;
      rsz_q   <= rsz_d;
      roff_q  <= roff_d;
      runs_q  <= runs_d;
    end
  end

endmodule
